// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, write and issue ports of the decode-stage register file
interface regfile_mp_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]    rna;
    logic [ADDR_W-1:0]    rnb;
    logic [DATA_W-1:0]    qa;
    logic [DATA_W-1:0]    qb;
    logic                 busya;
    logic                 busyb;
    logic                 we0;
    logic [ADDR_W-1:0]    wn0;
    logic [DATA_W-1:0]    d0;
    logic                 we1;
    logic [ADDR_W-1:0]    wn1;
    logic [DATA_W-1:0]    d1;
    logic                 iss_en;
    logic [ADDR_W-1:0]    iss_wn;
    logic [2**ADDR_W-1:0] busy_vec;

    modport master (
        output rna, rnb, we0, wn0, d0, we1, wn1, d1, iss_en, iss_wn,
        input  qa, qb, busya, busyb, busy_vec
    );

    modport slave (
        input  rna, rnb, we0, wn0, d0, we1, wn1, d1, iss_en, iss_wn,
        output qa, qb, busya, busyb, busy_vec
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: 2R/2W register file with same-cycle write bypass and pending scoreboard
module regfile_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic             clk,
    input logic             clr,
    regfile_mp_sb_if.slave  bus
);
    localparam int   N = 2**ADDR_W;
    localparam logic Z = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [N];
    logic [N-1:0]      busy;
    logic [N-1:0]      busy_nxt;
    logic              lw0, lw1, li;
    logic              ha0, ha1, hb0, hb1;

    // legality of this cycle's writes and issue; reset suppresses all of them
    always_comb begin
        lw0 = bus.we0 && !clr && !(Z && bus.wn0 == '0);
        lw1 = bus.we1 && !clr && !(Z && bus.wn1 == '0);
        li  = bus.iss_en && !clr && !(Z && bus.iss_wn == '0);
        ha0 = lw0 && bus.wn0 == bus.rna;
        ha1 = lw1 && bus.wn1 == bus.rna;
        hb0 = lw0 && bus.wn0 == bus.rnb;
        hb1 = lw1 && bus.wn1 == bus.rnb;
    end

    // read ports: port 1 bypass beats port 0, which beats stored data
    always_comb begin
        bus.qa    = (Z && bus.rna == '0) ? '0 : ha1 ? bus.d1 : ha0 ? bus.d0 : regs[bus.rna];
        bus.qb    = (Z && bus.rnb == '0) ? '0 : hb1 ? bus.d1 : hb0 ? bus.d0 : regs[bus.rnb];
        bus.busya = busy[bus.rna] && !(ha0 || ha1);
        bus.busyb = busy[bus.rnb] && !(hb0 || hb1);
    end

    // scoreboard: writeback clears, a fresh issue to the same register wins
    always_comb begin
        busy_nxt = busy;
        if (lw0) busy_nxt[bus.wn0] = 1'b0;
        if (lw1) busy_nxt[bus.wn1] = 1'b0;
        if (li) busy_nxt[bus.iss_wn] = 1'b1;
    end

    assign bus.busy_vec = busy;

    // storage update; port 1 is applied last so it wins a same-register collision
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (lw0) regs[bus.wn0] <= bus.d0;
            if (lw1) regs[bus.wn1] <= bus.d1;
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: table vectors, corner sequences and random traffic against a reference model
module tb_regfile_mp_sb;
    logic        clk = 1'b0;
    logic        clr;
    logic [4:0]  rna, rnb, wn0, wn1, iss_wn;
    logic [31:0] d0, d1;
    logic        we0, we1, iss_en;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mreg [2][32];
    logic        mbusy [2][32];

    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();

    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut1 (.clk(clk), .clr(clr), .bus(bus1.slave));
    regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut0 (.clk(clk), .clr(clr), .bus(bus0.slave));

    assign {bus1.rna, bus1.rnb, bus1.we0, bus1.wn0, bus1.d0, bus1.we1, bus1.wn1, bus1.d1, bus1.iss_en, bus1.iss_wn} =
           {rna, rnb, we0, wn0, d0, we1, wn1, d1, iss_en, iss_wn};
    assign {bus0.rna, bus0.rnb, bus0.we0, bus0.wn0, bus0.d0, bus0.we1, bus0.wn1, bus0.d1, bus0.iss_en, bus0.iss_wn} =
           {rna, rnb, we0, wn0, d0, we1, wn1, d1, iss_en, iss_wn};

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        we0;
        logic [4:0]  wn0;
        logic [31:0] d0;
        logic        we1;
        logic [4:0]  wn1;
        logic [31:0] d1;
        logic        iss_en;
        logic [4:0]  iss_wn;
        logic [4:0]  rna;
        logic [4:0]  rnb;
        logic [31:0] eqa;
        logic [31:0] eqb;
        logic        eba;
        logic        ebb;
    } vec_t;

    vec_t tv [12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic lw(input int z, input logic we, input logic [4:0] wn);
        return we && !clr && !(z != 0 && wn == 5'd0);
    endfunction

    function automatic logic hit(input int z, input logic [4:0] rn);
        return (lw(z, we1, wn1) && wn1 == rn) || (lw(z, we0, wn0) && wn0 == rn);
    endfunction

    function automatic logic [31:0] mq(input int z, input logic [4:0] rn);
        if (z != 0 && rn == 5'd0) return 32'd0;
        if (lw(z, we1, wn1) && wn1 == rn) return d1;
        if (lw(z, we0, wn0) && wn0 == rn) return d0;
        return mreg[z][rn];
    endfunction

    function automatic logic [31:0] mvec(input int z);
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = mbusy[z][r];
        return v;
    endfunction

    task automatic check_all();
        for (int z = 0; z < 2; z++) begin
            check($sformatf("m%0d_qa", z), 64'(z ? bus1.qa : bus0.qa), 64'(mq(z, rna)));
            check($sformatf("m%0d_qb", z), 64'(z ? bus1.qb : bus0.qb), 64'(mq(z, rnb)));
            check($sformatf("m%0d_busya", z), 64'(z ? bus1.busya : bus0.busya), 64'(mbusy[z][rna] && !hit(z, rna)));
            check($sformatf("m%0d_busyb", z), 64'(z ? bus1.busyb : bus0.busyb), 64'(mbusy[z][rnb] && !hit(z, rnb)));
            check($sformatf("m%0d_vec", z), 64'(z ? bus1.busy_vec : bus0.busy_vec), 64'(mvec(z)));
        end
    endtask

    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (clr) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[z][r] = 32'd0;
                    mbusy[z][r] = 1'b0;
                end
            end else begin
                if (lw(z, we0, wn0)) begin
                    mreg[z][wn0] = d0;
                    mbusy[z][wn0] = 1'b0;
                end
                if (lw(z, we1, wn1)) begin
                    mreg[z][wn1] = d1;
                    mbusy[z][wn1] = 1'b0;
                end
                if (iss_en && !(z != 0 && iss_wn == 5'd0)) mbusy[z][iss_wn] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        {clr, we0, we1, iss_en} = 4'b0;
        {wn0, wn1, iss_wn, d0, d1} = '0;
    endtask

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        rna = 5'd0;
        rnb = 5'd0;
        clr = 1'b1;
        #1;
        tick();
        clr = 1'b0;
        #2;
        check("rst_qa", 64'(bus1.qa), 64'd0);
        check("rst_vec", 64'(bus1.busy_vec), 64'd0);

        // random writes and issues, then a single reset edge wipes everything
        for (int i = 0; i < 20; i++) begin
            we0 = 1'b1; wn0 = 5'($urandom); d0 = $urandom;
            we1 = 1'b1; wn1 = 5'($urandom); d1 = $urandom;
            iss_en = 1'b1; iss_wn = 5'($urandom);
            tick();
        end
        idle();
        clr = 1'b1;
        tick();
        idle();
        for (int r = 0; r < 32; r++) begin
            rna = 5'(r);
            rnb = 5'(31 - r);
            #1;
            check("clr_qa1", 64'(bus1.qa), 64'd0);
            check("clr_qb0", 64'(bus0.qb), 64'd0);
        end
        check("clr_vec1", 64'(bus1.busy_vec), 64'd0);
        check("clr_vec0", 64'(bus0.busy_vec), 64'd0);
        tick();

        tv[0]  = '{1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd7, 5'd0, 32'hDEADBEEF, 32'd0,        1'b0, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 5'd9, 32'h11,       1'b1, 5'd9, 32'h22,   1'b0, 5'd0, 5'd9, 5'd9, 32'h22,       32'h22,       1'b0, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd9, 5'd9, 32'h22,       32'h22,       1'b0, 1'b0};
        tv[4]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b1, 5'd4, 5'd4, 5'd4, 32'd0,        32'd0,        1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd4, 5'd7, 32'd0,        32'hDEADBEEF, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 5'd4, 5'd4, 32'h44,       32'h44,       1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd4, 5'd4, 32'h44,       32'h44,       1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 5'd6, 32'h33,       1'b0, 5'd0, 32'd0,    1'b1, 5'd6, 5'd6, 5'd6, 32'h33,       32'h33,       1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd6, 5'd4, 32'h33,       32'h44,       1'b1, 1'b0};
        tv[10] = '{1'b1, 1'b1, 5'd3, 32'd5,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd3, 5'd6, 32'd0,        32'h33,       1'b0, 1'b1};
        tv[11] = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,    1'b0, 5'd0, 5'd3, 5'd6, 32'd0,        32'd0,        1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            {clr, we0, wn0, d0, we1, wn1, d1, iss_en, iss_wn, rna, rnb} =
                {tv[i].clr, tv[i].we0, tv[i].wn0, tv[i].d0, tv[i].we1, tv[i].wn1, tv[i].d1,
                 tv[i].iss_en, tv[i].iss_wn, tv[i].rna, tv[i].rnb};
            #2;
            check($sformatf("tv%0d_qa", i), 64'(bus1.qa), 64'(tv[i].eqa));
            check($sformatf("tv%0d_qb", i), 64'(bus1.qb), 64'(tv[i].eqb));
            check($sformatf("tv%0d_busya", i), 64'(bus1.busya), 64'(tv[i].eba));
            check($sformatf("tv%0d_busyb", i), 64'(bus1.busyb), 64'(tv[i].ebb));
            if (i == 5) check("tv5_vec4", 64'(bus1.busy_vec[4]), 64'd1);
            if (i == 7) check("tv7_vec4", 64'(bus1.busy_vec[4]), 64'd0);
            if (i == 9) check("tv9_vec6", 64'(bus1.busy_vec[6]), 64'd1);
            check_all();
            tick();
        end

        // register 0 handling differs between the two instances
        idle();
        we0 = 1'b1; wn0 = 5'd0; d0 = 32'hFF;
        iss_en = 1'b1; iss_wn = 5'd0;
        rna = 5'd0; rnb = 5'd0;
        #2;
        check("z1_qa_same", 64'(bus1.qa), 64'd0);
        check("z0_qa_same", 64'(bus0.qa), 64'hFF);
        tick();
        idle();
        #2;
        check("z1_qa_next", 64'(bus1.qa), 64'd0);
        check("z1_vec0", 64'(bus1.busy_vec[0]), 64'd0);
        check("z1_busya", 64'(bus1.busya), 64'd0);
        check("z0_qa_next", 64'(bus0.qa), 64'hFF);
        check("z0_vec0", 64'(bus0.busy_vec[0]), 64'd1);
        check("z0_busya", 64'(bus0.busya), 64'd1);
        tick();

        for (int i = 0; i < 600; i++) begin
            clr = ($urandom_range(0, 31) == 0);
            we0 = 1'($urandom); wn0 = raddr(); d0 = $urandom;
            we1 = 1'($urandom); wn1 = raddr(); d1 = $urandom;
            iss_en = 1'($urandom); iss_wn = raddr();
            rna = raddr(); rnb = raddr();
            #2;
            check_all();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
